// File: rtl/program_counter_pkg.sv
// ---------------------------------------------------------------------------
// program_counter_pkg
// Shared processor constants for the Troy WideWord fetch stage.
//   PC_WIDTH : width of a program counter in bits
//   PC_INCR  : byte distance to the next sequential instruction word
//   PC_RESET : program counter value after reset
//   pc_t     : program counter type, bit 0 is the MSB
// ---------------------------------------------------------------------------
package program_counter_pkg;

   localparam int unsigned PC_WIDTH = 32;
   localparam int unsigned PC_INCR  = 4;
   localparam logic [0:PC_WIDTH-1] PC_RESET = 32'h0;

   typedef logic [0:PC_WIDTH-1] pc_t;

endpackage : program_counter_pkg

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// Next-PC register for the fetch stage. Each rising clock edge it registers
// cur_pc + INCR, or RESET_PC while rst is high. The surrounding datapath
// feeds next_pc back in as cur_pc, so the pair forms the sequential fetch
// counter; branch selection happens upstream on cur_pc.
//
// Ports:
//   clk     : system clock, all state changes on the rising edge
//   rst     : synchronous active-high reset, wins over cur_pc
//   cur_pc  : current program counter, bit 0 is the MSB
//   next_pc : registered next program counter, bit 0 is the MSB
// ---------------------------------------------------------------------------
module program_counter
   import program_counter_pkg::*;
#(
   parameter int unsigned       WIDTH    = PC_WIDTH,
   parameter int unsigned       INCR     = PC_INCR,
   parameter logic [0:WIDTH-1]  RESET_PC = WIDTH'(PC_RESET)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [0:WIDTH-1]   cur_pc,
   output logic [0:WIDTH-1]   next_pc
);

   // Increment sized to the PC so the sum stays WIDTH bits wide and the
   // carry-out is simply dropped (modulo 2^WIDTH wrap).
   localparam logic [0:WIDTH-1] INCR_W = WIDTH'(INCR);

   // The only state in the block: next_pc is driven straight from this
   // register, so cur_pc never reaches the output combinationally and the
   // output holds between edges no matter how cur_pc moves.
   always_ff @(posedge clk) begin
      if (rst) begin
         next_pc <= RESET_PC;
      end else begin
         next_pc <= cur_pc + INCR_W;
      end
   end

endmodule : program_counter

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
// Self-checking bench for program_counter: directed steps followed by a
// randomized run, compared against a numeric reference model.
// ---------------------------------------------------------------------------
module tb_program_counter;

   logic          clk;
   logic          rst;
   logic [0:31]   cur_pc;
   logic [0:31]   next_pc;

   int compared;
   int mismatched;

   program_counter dut (
      .clk     (clk),
      .rst     (rst),
      .cur_pc  (cur_pc),
      .next_pc (next_pc)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the value the PC register should hold after an edge,
   // computed with plain wide arithmetic and an explicit modulo.
   function automatic logic [31:0] model_next(input bit r, input logic [31:0] cur);
      longint unsigned sum;
      if (r) return 32'h0;
      sum = (longint'(cur) + 64'd4) % 64'h1_0000_0000;
      return sum[31:0];
   endfunction

   // One comparison of next_pc against an expected value.
   task automatic checkOutput(input string tag, input logic [31:0] expected);
      logic [31:0] observed;
      observed = next_pc;
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive inputs well ahead of the edge, clock once, then sample 1 ns
   // after the edge and compare with the model.
   task automatic applyStimulus(input bit r, input logic [31:0] cur, input string tag);
      rst    = r;
      cur_pc = cur;
      @(posedge clk);
      #1;
      checkOutput(tag, model_next(r, cur));
   endtask

   initial begin
      logic [31:0] fb_model;
      logic [31:0] rnd_cur;
      bit          rnd_rst;

      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      cur_pc     = 32'h1234_5678;
      @(negedge clk);

      // Reset ignores cur_pc.
      applyStimulus(1'b1, 32'h1234_5678, "reset");

      // Basic increment and hold over later edges.
      applyStimulus(1'b0, 32'd200, "incr_200");
      applyStimulus(1'b0, 32'd200, "hold_200_a");
      applyStimulus(1'b0, 32'd200, "hold_200_b");

      // No combinational path: wiggle cur_pc between edges.
      #2 cur_pc = 32'hDEAD_BEEF;
      #1 checkOutput("no_comb_a", 32'd204);
      cur_pc = 32'h0000_0010;
      #1 checkOutput("no_comb_b", 32'd204);
      applyStimulus(1'b0, 32'h0000_0010, "after_toggle");

      // Feedback loop: next_pc looped back every two cycles from 200.
      applyStimulus(1'b0, 32'd200, "loop_start");
      fb_model = 32'd204;
      for (int i = 0; i < 16; i++) begin
         cur_pc = next_pc;
         @(posedge clk);
         @(posedge clk);
         #1;
         checkOutput("loop_step", fb_model + 32'd4);
         fb_model = fb_model + 32'd4;
      end
      checkOutput("loop_final", 32'd268);

      // Wrap-around with carry-out discarded.
      applyStimulus(1'b0, 32'hFFFF_FFFC, "wrap_fffc");
      applyStimulus(1'b0, 32'hFFFF_FFFF, "wrap_ffff");

      // Reset in the middle of a run, then recovery.
      applyStimulus(1'b0, 32'h0000_1000, "run_1000");
      applyStimulus(1'b1, 32'h0000_1000, "mid_reset");
      applyStimulus(1'b0, 32'h0000_1000, "post_reset");

      // Randomized run, biased towards the wrap boundary now and then.
      for (int i = 0; i < 200; i++) begin
         rnd_rst = ($urandom_range(7) == 0);
         rnd_cur = $urandom;
         if ($urandom_range(5) == 0) rnd_cur = 32'hFFFF_FFF0 | 32'($urandom_range(15));
         applyStimulus(rnd_rst, rnd_cur, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_program_counter
